// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the valid/ready
// handshake toward decode. The fetch controller is the master.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WORD_WIDTH-1:0] mem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [WORD_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;

  modport master (
    output mem_en_o,
    output mem_addr_o,
    input  mem_rdata_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_o,
    output instr_pc_o
  );

  modport slave (
    input  mem_en_o,
    input  mem_addr_o,
    output mem_rdata_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_o,
    input  instr_pc_o
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational-read instruction memory,
// buffers {word, pc} in a small prefetch FIFO, handles branch flush and halt drain.
module instr_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  halt_i,
  output logic                  misaligned_o,
  output logic                  halted_o,
  instr_fetch_ctrl_if.master    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(3'd4);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1'b1);

  logic [0:0]            state_r;
  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic                  misaligned_r;
  logic [WORD_WIDTH-1:0] data_mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];

  logic                  valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic [CNT_W-1:0]      count_nxt_s;

  assign valid_s = (count_r != CNT_ZERO);
  assign pop_s   = valid_s & bus.instr_ready_i;

  // Fetch issue: a pop frees a slot in the same cycle, so a full FIFO still streams.
  always_comb begin
    push_s = 1'b0;
    if (rst_i) begin
      push_s = 1'b0;
    end else if ((state_r == RUN) && !halt_i && !branch_i &&
                 ((count_r < CNT_FULL) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Occupancy update for the non-branch case.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: run/halt FSM, fetch PC, FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= RUN;
      fetch_pc_r   <= boot_addr_i & ALIGN_MASK;
      count_r      <= CNT_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      misaligned_r <= 1'b0;
    end else begin
      case (state_r)
        RUN:     state_r <= halt_i ? HALT : RUN;
        HALT:    state_r <= halt_i ? HALT : RUN;
        default: state_r <= RUN;
      endcase
      misaligned_r <= branch_i & (branch_target_i[1:0] != 2'b00);
      // A branch flushes everything buffered; any pop this cycle already completed.
      if (branch_i) begin
        count_r    <= CNT_ZERO;
        wr_ptr_r   <= PTR_ZERO;
        rd_ptr_r   <= PTR_ZERO;
        fetch_pc_r <= branch_target_i & ALIGN_MASK;
      end else begin
        count_r <= count_nxt_s;
        if (push_s) begin
          wr_ptr_r   <= wr_ptr_r + PTR_ONE;
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
    end
  end

  // FIFO storage; cleared on reset so the head outputs never expose pre-reset data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {WORD_WIDTH{1'b0}};
        pc_mem_r[i]   <= {ADDR_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= bus.mem_rdata_i;
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
    end
  end

  assign bus.mem_en_o      = push_s;
  assign bus.mem_addr_o    = fetch_pc_r;
  assign bus.instr_valid_o = valid_s;
  assign bus.instr_o       = data_mem_r[rd_ptr_r];
  assign bus.instr_pc_o    = pc_mem_r[rd_ptr_r];
  assign misaligned_o      = misaligned_r;
  assign halted_o          = (state_r == HALT) && (count_r == CNT_ZERO);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: stimulus queues expected PCs, a monitor
// checks every accepted instruction; cycle-level checks cover fetch/branch/halt/reset.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] MAGIC = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_addr;
  logic        branch;
  logic [31:0] branch_target;
  logic        halt;
  logic        misaligned;
  logic        halted;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  int          fetches;

  instr_fetch_ctrl_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  // Memory model: each word is its address scrambled by a constant.
  assign bus.mem_rdata_i = bus.mem_addr_o ^ MAGIC;

  instr_fetch_ctrl #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .DEPTH(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .boot_addr_i     (boot_addr),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .halt_i          (halt),
    .misaligned_o    (misaligned),
    .halted_o        (halted),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted head must match the next queued PC.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.instr_valid_o === 1'b1 && bus.instr_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h expected none", bus.instr_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_pc", bus.instr_pc_o, mon_exp);
        chk("pop_instr", bus.instr_o, mon_exp ^ MAGIC);
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; boot_addr = 32'h0000_0100; branch = 1'b0; branch_target = 32'h0;
    halt = 1'b0; bus.instr_ready_i = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en_o, 32'd0);
    chk("rst_valid", bus.instr_valid_o, 32'd0);
    chk("rst_misaligned", misaligned, 32'd0);
    chk("rst_halted", halted, 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_instr_pc", bus.instr_pc_o, 32'd0);
    tick();

    // Streaming from boot address with ready held high
    rst = 1'b0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    @(negedge clk);
    chk("c0_mem_en", bus.mem_en_o, 32'd1);
    chk("c0_addr", bus.mem_addr_o, 32'h100);
    chk("c0_valid", bus.instr_valid_o, 32'd0);
    tick();
    @(negedge clk);
    chk("c1_addr", bus.mem_addr_o, 32'h104);
    chk("c1_valid", bus.instr_valid_o, 32'd1);
    tick();
    @(negedge clk);
    chk("c2_addr", bus.mem_addr_o, 32'h108);
    tick();
    rst = 1'b1; bus.instr_ready_i = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_valid", bus.instr_valid_o, 32'd0);
    chk("drain_p1", exp_q.size(), 32'd0);
    tick();

    // Back-pressure: ready low for five cycles, FIFO fills to two
    rst = 1'b0;
    fetches = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.mem_en_o === 1'b1) fetches++;
      if (i >= 1) begin
        chk("hold_valid", bus.instr_valid_o, 32'd1);
        chk("hold_pc", bus.instr_pc_o, 32'h100);
      end
      tick();
    end
    chk("bp_fetch_count", fetches, 32'd2);
    bus.instr_ready_i = 1'b1;
    exp_q.push_back(32'h100);
    @(negedge clk);
    chk("bp_resume_en", bus.mem_en_o, 32'd1);
    chk("bp_resume_addr", bus.mem_addr_o, 32'h108);
    tick();

    // Aligned branch while 0x104/0x108 are buffered and not consumed
    bus.instr_ready_i = 1'b0; branch = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    chk("br_cycle_en", bus.mem_en_o, 32'd0);
    tick();
    branch = 1'b0; bus.instr_ready_i = 1'b1;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    chk("br_n1_valid", bus.instr_valid_o, 32'd0);
    chk("br_n1_en", bus.mem_en_o, 32'd1);
    chk("br_n1_addr", bus.mem_addr_o, 32'h200);
    chk("br_n1_misaligned", misaligned, 32'd0);
    tick();
    @(negedge clk);
    chk("br_n2_valid", bus.instr_valid_o, 32'd1);
    chk("br_n2_pc", bus.instr_pc_o, 32'h200);
    tick();

    // Misaligned branch target; pop of 0x204 in the branch cycle completes
    branch = 1'b1; branch_target = 32'h203;
    @(negedge clk);
    chk("mis_cycle_en", bus.mem_en_o, 32'd0);
    tick();
    branch = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    chk("mis_pulse", misaligned, 32'd1);
    chk("mis_addr", bus.mem_addr_o, 32'h200);
    chk("mis_valid", bus.instr_valid_o, 32'd0);
    tick();
    bus.instr_ready_i = 1'b0;
    @(negedge clk);
    chk("mis_pulse_end", misaligned, 32'd0);
    chk("mis_fetch2_addr", bus.mem_addr_o, 32'h204);
    tick();

    // Halt with two entries buffered: drain, then halted_o
    halt = 1'b1; bus.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("halt_c0_en", bus.mem_en_o, 32'd0);
    chk("halt_c0_pc", bus.instr_pc_o, 32'h200);
    tick();
    @(negedge clk);
    chk("halt_c1_en", bus.mem_en_o, 32'd0);
    chk("halt_c1_halted", halted, 32'd0);
    tick();
    @(negedge clk);
    chk("halt_c2_halted", halted, 32'd1);
    chk("halt_c2_valid", bus.instr_valid_o, 32'd0);
    chk("halt_c2_en", bus.mem_en_o, 32'd0);
    tick();
    halt = 1'b0;
    exp_q.push_back(32'h208);
    @(negedge clk);
    chk("unhalt_c0_en", bus.mem_en_o, 32'd0);
    chk("unhalt_c0_halted", halted, 32'd1);
    tick();
    @(negedge clk);
    chk("unhalt_c1_en", bus.mem_en_o, 32'd1);
    chk("unhalt_c1_addr", bus.mem_addr_o, 32'h208);
    chk("unhalt_c1_halted", halted, 32'd0);
    tick();
    @(negedge clk);
    chk("unhalt_c2_pc", bus.instr_pc_o, 32'h208);
    tick();

    // PC wrap from the top of the address space, then mid-stream reset
    rst = 1'b1; bus.instr_ready_i = 1'b0; boot_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("drain_p2", exp_q.size(), 32'd0);
    tick();
    tick();
    rst = 1'b0; bus.instr_ready_i = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    chk("wrap_addr0", bus.mem_addr_o, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_addr1", bus.mem_addr_o, 32'h0000_0000);
    tick();
    @(negedge clk);
    chk("wrap_addr2", bus.mem_addr_o, 32'h0000_0004);
    tick();
    rst = 1'b1; bus.instr_ready_i = 1'b0;
    @(negedge clk);
    chk("prerst_valid", bus.instr_valid_o, 32'd1);
    tick();
    @(negedge clk);
    chk("postrst_valid", bus.instr_valid_o, 32'd0);
    chk("postrst_pc", bus.instr_pc_o, 32'd0);
    chk("postrst_instr", bus.instr_o, 32'd0);
    chk("postrst_en", bus.mem_en_o, 32'd0);
    tick();
    rst = 1'b0; halt = 1'b1;
    @(negedge clk);
    chk("rel_valid", bus.instr_valid_o, 32'd0);
    chk("rel_halted", halted, 32'd0);
    chk("drain_p3", exp_q.size(), 32'd0);
    tick();
    @(negedge clk);
    chk("final_halted", halted, 32'd1);
    chk("final_en", bus.mem_en_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the single-port, combinational-read instruction memory for the core.
- Holds the fetch PC and issues one word fetch per cycle while there is room.
- Buffers fetched words with their PCs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirect/flush and a halt request that drains the FIFO.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the fetch PC and memory address.
- WORD_WIDTH, 32, instruction word width.
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- boot_addr_i  in  ADDR_WIDTH  reset PC; sampled while rst_i=1, low 2 bits forced to 0
- mem_en_o  out  1  memory read enable
- mem_addr_o  out  ADDR_WIDTH  word-aligned fetch address (= fetch_pc)
- mem_rdata_i  in  WORD_WIDTH  read data, valid in the same cycle as mem_en_o
- branch_i  in  1  redirect request (single-cycle pulse)
- branch_target_i  in  ADDR_WIDTH  redirect target
- halt_i  in  1  level; stop issuing fetches
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  decode accepts head
- instr_o  out  WORD_WIDTH  head instruction
- instr_pc_o  out  ADDR_WIDTH  head PC
- misaligned_o  out  1  one-cycle pulse: branch target had nonzero low bits
- halted_o  out  1  halted and FIFO empty

Behaviour:
Reset:
- fetch_pc = {boot_addr_i[ADDR_WIDTH-1:2],2'b00}; count = 0; state = RUN.
- Outputs during reset: mem_en_o, instr_valid_o, misaligned_o, halted_o = 0; instr_o = 0; instr_pc_o = 0.
- Reset asserted mid-operation discards all FIFO contents and any pending fetch. No output depends on pre-reset state.

State machine: RUN, HALT.
- RUN → HALT when halt_i=1.
- HALT → RUN when halt_i=0.
- branch_i is honoured in both states.

Handshake:
- pop = instr_valid_o & instr_ready_i.
- instr_valid_o = (count != 0), driven from registers only.
- Head outputs hold stable while valid and not popped.

Fetch:
- mem_en_o = (state==RUN) & ~halt_i & ~branch_i & (count<DEPTH | pop).
- On a fetch, push {mem_rdata_i, fetch_pc} and set fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Push on an empty FIFO makes instr_valid_o=1 in the next cycle. Fetch-to-valid latency is 1 cycle.
- Throughput is 1 instruction/cycle with instr_ready_i held high.

Branch (priority over fetch and halt):
- In the branch cycle: no fetch. A pop in that cycle completes normally (the consumer keeps that word).
- Next cycle: FIFO emptied (count=0), fetch_pc = {branch_target_i[ADDR_WIDTH-1:2],2'b00}.
- misaligned_o = 1 for one cycle (the cycle after branch_i) if branch_target_i[1:0] != 0.
- First fetch of the target is at N+1; instr_valid_o is at N+2.

Halt:
- No new fetches while halted. Existing entries still drain via the handshake.
- halted_o = (state==HALT) & (count==0), registered-state based.
- On deassertion of halt_i, fetching resumes from fetch_pc the cycle after deassertion.

Arithmetic:
- count width is $clog2(DEPTH)+1.
- FIFO pointers wrap modulo DEPTH.
- fetch_pc low 2 bits are always 0.

Test Plan:
- Reset with boot_addr_i=0x100, instr_ready_i=1 → mem_addr_o 0x100, 0x104, 0x108 on consecutive cycles; instr_pc_o 0x100 with instr_valid_o first high 1 cycle after the first fetch; one instr per cycle.
- instr_ready_i=0 for 5 cycles after reset (DEPTH=2) → exactly 2 fetches, then mem_en_o=0; head holds 0x100. Raise ready → 0x100, 0x104, 0x108 in order with no gap and no duplicate.
- branch_i with target 0x200 while the FIFO holds 0x104/0x108 → next cycle count=0; fetch at 0x200; instr_pc_o=0x200 valid at N+2; 0x104/0x108 are never presented after the branch.
- branch target 0x203 → misaligned_o pulses once; fetch address 0x200.
- halt_i=1 with 2 entries buffered and ready=1 → no mem_en_o; 2 pops; halted_o=1 after the FIFO empties. halt_i=0 → fetch resumes at the next sequential PC.
- boot_addr_i=0xFFFFFFFC, ready=1 → fetched PCs 0xFFFFFFFC then 0x00000000 (wrap). Assert rst_i mid-stream → instr_valid_o=0 next cycle and the FIFO is empty.
